// File: rtl/back_icon_scheduler_pkg.sv
// Shared types and helpers for the icon transfer scheduler.
// Instruction typedefs are sized for the default 4-EU / 2-op interconnect.
package back_icon_scheduler_pkg;

    localparam int DEF_NUM_EXEC_UNITS = 4;
    localparam int DEF_OPS_PER_EU     = 2;
    localparam int DEF_RX_W           = DEF_NUM_EXEC_UNITS * DEF_OPS_PER_EU;
    localparam int DEF_EU_ADDR_W      = $clog2(DEF_NUM_EXEC_UNITS);

    typedef logic [DEF_EU_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [DEF_RX_W-1:0]      type_icon_receivers_list;

    typedef struct packed {
        type_exec_unit_addr      src_addr;
        type_icon_receivers_list receiver_list;
    } type_icon_instr;

    typedef enum logic {
        ICH_IDLE   = 1'b0,
        ICH_ACTIVE = 1'b1
    } type_icon_ch_state;

    // Width helper that never returns zero, so degenerate parameters still give legal vectors.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/back_icon_scheduler_if.sv
// Dispatch and per-channel bus bundle between the scheduler and its environment.
interface back_icon_scheduler_if #(
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int NUM_EXEC_UNITS    = 4,
    parameter int OPS_PER_EU        = 2
) ();
    import back_icon_scheduler_pkg::*;

    localparam int RX_W      = NUM_EXEC_UNITS * OPS_PER_EU;
    localparam int EU_ADDR_W = clog2_min1(NUM_EXEC_UNITS);

    logic [EU_ADDR_W-1:0]                   instr_src_i;
    logic [RX_W-1:0]                        instr_rx_list_i;
    logic                                   instr_valid_i;
    logic                                   instr_ready_o;
    logic [NUM_ICON_CHANNELS*EU_ADDR_W-1:0] ch_src_addr_o;
    logic [NUM_ICON_CHANNELS*RX_W-1:0]      ch_receiver_list_o;
    logic [NUM_ICON_CHANNELS-1:0]           ch_valid_o;
    logic [NUM_ICON_CHANNELS*RX_W-1:0]      ch_success_list_i;
    logic [NUM_ICON_CHANNELS-1:0]           ch_timeout_o;
    logic                                   busy_o;

    modport master (
        output instr_src_i, instr_rx_list_i, instr_valid_i, ch_success_list_i,
        input  instr_ready_o, ch_src_addr_o, ch_receiver_list_o, ch_valid_o, ch_timeout_o, busy_o
    );

    modport slave (
        input  instr_src_i, instr_rx_list_i, instr_valid_i, ch_success_list_i,
        output instr_ready_o, ch_src_addr_o, ch_receiver_list_o, ch_valid_o, ch_timeout_o, busy_o
    );

endinterface

// File: rtl/back_icon_sched_fifo.sv
// Synchronous instruction FIFO; full/empty come only from registered pointers with a wrap bit.
module back_icon_sched_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    T               mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/back_icon_scheduler.sv
// Buffers icon transfer instructions and issues them in order, round-robin, onto a pool of
// channels that track pending receivers until every receiver has reported success.
module back_icon_scheduler
    import back_icon_scheduler_pkg::*;
#(
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int NUM_EXEC_UNITS    = 4,
    parameter int OPS_PER_EU        = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    back_icon_scheduler_if.slave bus
);
    localparam int NCH       = NUM_ICON_CHANNELS;
    localparam int RX_W      = NUM_EXEC_UNITS * OPS_PER_EU;
    localparam int EU_ADDR_W = clog2_min1(NUM_EXEC_UNITS);
    localparam int CH_W      = clog2_min1(NCH);
    localparam int CNT_W     = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic [EU_ADDR_W-1:0] src_addr;
        logic [RX_W-1:0]      receiver_list;
    } instr_t;

    // Returns {found, index} of the first idle channel at or after start, wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] idle, input logic [CH_W-1:0] start);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NCH;
            if (idle[idx]) res = {1'b1, CH_W'(idx)};
        end
        return res;
    endfunction

    instr_t           fifo_head;
    instr_t           push_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;

    logic [CH_W-1:0]  rr_reg;
    logic [NCH-1:0]   ch_active;
    logic [NCH-1:0]   src_match;
    logic [NCH-1:0]   issue_onehot;
    logic [CH_W:0]    pick_res;
    logic [CH_W-1:0]  pick_idx;
    logic             pick_found;
    logic             head_empty_list;
    logic             src_conflict;
    logic             can_issue;

    logic [NCH*EU_ADDR_W-1:0] src_out;
    logic [NCH*RX_W-1:0]      list_out;
    logic [NCH-1:0]           timeout_out;

    assign push_data.src_addr      = bus.instr_src_i;
    assign push_data.receiver_list = bus.instr_rx_list_i;
    assign fifo_push               = bus.instr_valid_i && !fifo_full;

    back_icon_sched_fifo #(
        .T     (instr_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue decisions only look at registered channel state, so a channel that finishes
    // this cycle still counts as busy (and still holds its source) until next cycle.
    always_comb begin
        head_empty_list = (fifo_head.receiver_list == '0);
        src_conflict    = |(ch_active & src_match);
        pick_res        = rr_pick(~ch_active, rr_reg);
        pick_found      = pick_res[CH_W];
        pick_idx        = pick_res[CH_W-1:0];
        can_issue       = !fifo_empty && !head_empty_list && pick_found && !src_conflict;
        fifo_pop        = !fifo_empty && (head_empty_list || can_issue);
        issue_onehot    = '0;
        if (can_issue) issue_onehot[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_reg <= '0;
        end else if (can_issue) begin
            rr_reg <= CH_W'((int'(pick_idx) + 1) % NCH);
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        type_icon_ch_state    state_reg;
        logic [EU_ADDR_W-1:0] src_reg;
        logic [RX_W-1:0]      pend_reg;
        logic [CNT_W-1:0]     cnt_reg;
        logic                 timeout_reg;
        logic [RX_W-1:0]      remaining;

        assign remaining = pend_reg & ~bus.ch_success_list_i[gi*RX_W +: RX_W];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_reg   <= ICH_IDLE;
                src_reg     <= '0;
                pend_reg    <= '0;
                cnt_reg     <= '0;
                timeout_reg <= 1'b0;
            end else begin
                timeout_reg <= 1'b0;
                case (state_reg)
                    ICH_IDLE: begin
                        if (issue_onehot[gi]) begin
                            state_reg <= ICH_ACTIVE;
                            src_reg   <= fifo_head.src_addr;
                            pend_reg  <= fifo_head.receiver_list;
                            cnt_reg   <= '0;
                        end
                    end
                    ICH_ACTIVE: begin
                        if (remaining == '0) begin
                            state_reg <= ICH_IDLE;
                            src_reg   <= '0;
                            pend_reg  <= '0;
                            cnt_reg   <= '0;
                        end else begin
                            pend_reg <= remaining;
                            // Timeout is a retry hint only: the channel keeps driving what is left.
                            if (TIMEOUT_CYCLES > 0) begin
                                if (cnt_reg == CNT_LAST) begin
                                    timeout_reg <= 1'b1;
                                    cnt_reg     <= '0;
                                end else begin
                                    cnt_reg <= cnt_reg + 1'b1;
                                end
                            end
                        end
                    end
                    default: state_reg <= ICH_IDLE;
                endcase
            end
        end

        assign ch_active[gi]                        = (state_reg == ICH_ACTIVE);
        assign src_match[gi]                        = (src_reg == fifo_head.src_addr);
        assign src_out[gi*EU_ADDR_W +: EU_ADDR_W]   = src_reg;
        assign list_out[gi*RX_W +: RX_W]            = pend_reg;
        assign timeout_out[gi]                      = timeout_reg;
    end

    assign bus.instr_ready_o      = !fifo_full;
    assign bus.ch_src_addr_o      = src_out;
    assign bus.ch_receiver_list_o = list_out;
    assign bus.ch_valid_o         = ch_active;
    assign bus.ch_timeout_o       = timeout_out;
    assign bus.busy_o             = !fifo_empty || (|ch_active);

endmodule
